// File: rtl/writeback_commit_pkg.sv
// writeback_commit_pkg: shared widths, request/TLB/exception types and cause priority for the writeback stage
package writeback_commit_pkg;
  localparam int INSTR_ID_WIDTH = 4;
  localparam int REG_FILE_ADDR_WIDTH = 5;
  localparam int REG_FILE_DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  typedef enum logic [2:0] {
    XCPT_NONE,
    XCPT_FETCH,
    XCPT_DECODE,
    XCPT_ALU,
    XCPT_MUL,
    XCPT_DTLB_MISS
  } xcpt_cause_e;
  typedef struct packed {
    logic [19:0] vpn;
    logic [19:0] ppn;
  } tlb_req_info_t;
  typedef struct packed {
    logic [INSTR_ID_WIDTH-1:0] instr_id;
    logic [ADDR_WIDTH-1:0] pc;
    logic rf_wen;
    logic [REG_FILE_ADDR_WIDTH-1:0] rf_dest;
    logic [REG_FILE_DATA_WIDTH-1:0] rf_data;
    logic tlbwrite;
    tlb_req_info_t tlb_info;
    logic xcpt_fetch;
    logic xcpt_decode;
    logic xcpt_alu;
    logic xcpt_mul;
    logic xcpt_dtlb_miss;
    logic [ADDR_WIDTH-1:0] xcpt_addr;
  } writeback_request_t;
  typedef struct packed {
    xcpt_cause_e cause;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] addr;
  } commit_xcpt_t;
  function automatic xcpt_cause_e xcpt_cause(input writeback_request_t r);
    return r.xcpt_fetch ? XCPT_FETCH : r.xcpt_decode ? XCPT_DECODE : r.xcpt_alu ? XCPT_ALU :
           r.xcpt_mul ? XCPT_MUL : r.xcpt_dtlb_miss ? XCPT_DTLB_MISS : XCPT_NONE;
  endfunction
endpackage

// File: rtl/writeback_commit_rob_storage.sv
// writeback_commit_rob_storage: ROB slot array with valid bits, two fill ports and one head read port
module writeback_commit_rob_storage import writeback_commit_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int ID_W = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic a_en,
  input  writeback_request_t a_info,
  input  logic b_en,
  input  writeback_request_t b_info,
  input  logic clr_en,
  input  logic [ID_W-1:0] clr_idx,
  input  logic clr_all,
  input  logic [ID_W-1:0] rd_idx,
  output logic rd_valid,
  output writeback_request_t rd_info,
  output logic [DEPTH-1:0] valid
);
  writeback_request_t slots [DEPTH];
  logic [ID_W-1:0] a_idx, b_idx;
  assign a_idx = a_info.instr_id[ID_W-1:0];
  assign b_idx = b_info.instr_id[ID_W-1:0];
  assign rd_valid = valid[rd_idx];
  assign rd_info = slots[rd_idx];
  always_ff @(posedge clock) begin
    if (reset || clr_all) valid <= '0;
    else begin
      if (clr_en) valid[clr_idx] <= 1'b0;
      if (b_en) valid[b_idx] <= 1'b1;
      if (a_en) valid[a_idx] <= 1'b1;
    end
  end
  // port a is written last so the cache result wins a same-slot collision
  always_ff @(posedge clock) begin
    if (b_en) slots[b_idx] <= b_info;
    if (a_en) slots[a_idx] <= a_info;
  end
endmodule

// File: rtl/writeback_commit.sv
// writeback_commit: in-order ROB commit of cache/mul results into RF writes, TLB writes or exception flushes
module writeback_commit import writeback_commit_pkg::*; #(
  parameter int ROB_DEPTH = 8,
  parameter int ROB_ID_W = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic alloc_valid,
  output logic rob_full,
  input  logic cache_wb_valid,
  input  writeback_request_t cache_wb_info,
  input  logic mul_wb_valid,
  input  writeback_request_t mul_wb_info,
  output logic rf_wen,
  output logic [REG_FILE_ADDR_WIDTH-1:0] rf_dest,
  output logic [REG_FILE_DATA_WIDTH-1:0] rf_data,
  output logic new_tlb_entry,
  output tlb_req_info_t new_tlb_info,
  output logic xcpt_valid,
  output commit_xcpt_t xcpt_info,
  output logic flush_pipeline,
  output logic commit_valid,
  output logic [INSTR_ID_WIDTH-1:0] commit_instr_id
);
  localparam logic [ROB_ID_W:0] ONE = (ROB_ID_W+1)'(1);
  localparam logic [ROB_ID_W:0] DEPTH_W = (ROB_ID_W+1)'(ROB_DEPTH);
  logic [ROB_ID_W:0] head, tail, count, restart;
  logic [ROB_ID_W-1:0] cache_slot, mul_slot;
  logic [ROB_DEPTH-1:0] valid;
  logic commit, is_xcpt, take;
  writeback_request_t head_info;
  xcpt_cause_e cause;
  assign cause = xcpt_cause(head_info);
  assign is_xcpt = cause != XCPT_NONE;
  assign take = !flush_pipeline && !(commit && is_xcpt);
  assign restart = head_info.instr_id[ROB_ID_W:0] + ONE;
  assign count = tail - head;
  assign rob_full = count == DEPTH_W;
  assign cache_slot = cache_wb_info.instr_id[ROB_ID_W-1:0];
  assign mul_slot = mul_wb_info.instr_id[ROB_ID_W-1:0];
  writeback_commit_rob_storage #(.DEPTH(ROB_DEPTH), .ID_W(ROB_ID_W)) u_rob (
    .clock(clock),
    .reset(reset),
    .a_en(cache_wb_valid && take),
    .a_info(cache_wb_info),
    .b_en(mul_wb_valid && take),
    .b_info(mul_wb_info),
    .clr_en(commit && !is_xcpt),
    .clr_idx(head[ROB_ID_W-1:0]),
    .clr_all(commit && is_xcpt),
    .rd_idx(head[ROB_ID_W-1:0]),
    .rd_valid(commit),
    .rd_info(head_info),
    .valid(valid)
  );
  // an exception rewinds both pointers to the id after the faulting one
  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else if (commit && is_xcpt) begin
      head <= restart;
      tail <= restart;
    end else begin
      if (commit) head <= head + ONE;
      if (alloc_valid && !flush_pipeline) tail <= tail + ONE;
    end
  end
  always_ff @(posedge clock) begin
    rf_wen <= 1'b0;
    rf_dest <= '0;
    rf_data <= '0;
    new_tlb_entry <= 1'b0;
    new_tlb_info <= '0;
    xcpt_valid <= 1'b0;
    xcpt_info <= '0;
    flush_pipeline <= 1'b0;
    commit_valid <= 1'b0;
    commit_instr_id <= '0;
    if (!reset && commit && is_xcpt) begin
      xcpt_valid <= 1'b1;
      flush_pipeline <= 1'b1;
      xcpt_info <= '{cause: cause, pc: head_info.pc, addr: head_info.xcpt_addr};
    end else if (!reset && commit) begin
      rf_wen <= head_info.rf_wen;
      rf_dest <= head_info.rf_dest;
      rf_data <= head_info.rf_data;
      new_tlb_entry <= head_info.tlbwrite;
      new_tlb_info <= head_info.tlb_info;
      commit_valid <= 1'b1;
      commit_instr_id <= head_info.instr_id;
    end
  end
  assert property (@(posedge clock) disable iff (reset || flush_pipeline) !(alloc_valid && rob_full));
  assert property (@(posedge clock) disable iff (reset || flush_pipeline)
    !(cache_wb_valid && mul_wb_valid && cache_slot == mul_slot));
  assert property (@(posedge clock) disable iff (reset || flush_pipeline) !(cache_wb_valid && valid[cache_slot]));
  assert property (@(posedge clock) disable iff (reset || flush_pipeline) !(mul_wb_valid && valid[mul_slot]));
endmodule

// File: tb/tb_writeback_commit.sv
// tb_writeback_commit: directed vectors for in-order/out-of-order commit, exceptions, full/wrap and reset
module tb_writeback_commit;
  import writeback_commit_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic alloc_valid = 1'b0;
  logic rob_full;
  logic cache_wb_valid = 1'b0;
  writeback_request_t cache_wb_info = '0;
  logic mul_wb_valid = 1'b0;
  writeback_request_t mul_wb_info = '0;
  logic rf_wen;
  logic [REG_FILE_ADDR_WIDTH-1:0] rf_dest;
  logic [REG_FILE_DATA_WIDTH-1:0] rf_data;
  logic new_tlb_entry;
  tlb_req_info_t new_tlb_info;
  logic xcpt_valid;
  commit_xcpt_t xcpt_info;
  logic flush_pipeline;
  logic commit_valid;
  logic [INSTR_ID_WIDTH-1:0] commit_instr_id;
  int checks = 0;
  int failures = 0;
  writeback_request_t req;
  writeback_commit dut (
    .clock(clock),
    .reset(reset),
    .alloc_valid(alloc_valid),
    .rob_full(rob_full),
    .cache_wb_valid(cache_wb_valid),
    .cache_wb_info(cache_wb_info),
    .mul_wb_valid(mul_wb_valid),
    .mul_wb_info(mul_wb_info),
    .rf_wen(rf_wen),
    .rf_dest(rf_dest),
    .rf_data(rf_data),
    .new_tlb_entry(new_tlb_entry),
    .new_tlb_info(new_tlb_info),
    .xcpt_valid(xcpt_valid),
    .xcpt_info(xcpt_info),
    .flush_pipeline(flush_pipeline),
    .commit_valid(commit_valid),
    .commit_instr_id(commit_instr_id)
  );
  always #5 clock = ~clock;
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
    alloc_valid = 1'b0;
    cache_wb_valid = 1'b0;
    mul_wb_valid = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic alloc(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1'b1;
      tick();
    end
  endtask
  function automatic writeback_request_t mk(input logic [3:0] id, input logic [31:0] data, input logic [4:0] x);
    writeback_request_t r;
    r = '0;
    r.instr_id = id;
    r.pc = 32'h1000 + {26'd0, id, 2'b00};
    r.rf_wen = 1'b1;
    r.rf_dest = {1'b0, id} + 5'd5;
    r.rf_data = data;
    {r.xcpt_fetch, r.xcpt_decode, r.xcpt_alu, r.xcpt_mul, r.xcpt_dtlb_miss} = x;
    return r;
  endfunction
  task automatic fill_cache(input logic [3:0] id, input logic [31:0] data, input logic [4:0] x);
    cache_wb_info = mk(id, data, x);
    cache_wb_valid = 1'b1;
  endtask
  task automatic fill_mul(input logic [3:0] id, input logic [31:0] data);
    mul_wb_info = mk(id, data, 5'b0);
    mul_wb_valid = 1'b1;
  endtask
  task automatic expect_commit(input string tag, input logic [3:0] id, input logic [31:0] data);
    check({tag, ".cv"}, commit_valid, 1'b1);
    check({tag, ".id"}, commit_instr_id, id);
    check({tag, ".wen"}, rf_wen, 1'b1);
    check({tag, ".dest"}, rf_dest, {1'b0, id} + 5'd5);
    check({tag, ".data"}, rf_data, data);
    check({tag, ".xv"}, xcpt_valid, 1'b0);
  endtask
  task automatic expect_idle(input string tag);
    check({tag, ".cv"}, commit_valid, 1'b0);
    check({tag, ".wen"}, rf_wen, 1'b0);
    check({tag, ".flush"}, flush_pipeline, 1'b0);
  endtask
  initial begin
    do_reset();
    expect_idle("reset");
    check("reset.full", rob_full, 1'b0);
    check("reset.xv", xcpt_valid, 1'b0);
    check("reset.tlb", new_tlb_entry, 1'b0);
    // in-order fill, id1 also writes the TLB
    alloc(4);
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        req = mk(4'(i), 32'hA5 + 32'(i), 5'b0);
        req.tlbwrite = (i == 1);
        req.tlb_info = '{vpn: 20'h12345, ppn: 20'h00abc};
        cache_wb_info = req;
        cache_wb_valid = 1'b1;
      end
      tick();
      if (i == 0) expect_idle("inord.first");
      else begin
        expect_commit($sformatf("inord%0d", i - 1), 4'(i - 1), 32'hA5 + 32'(i - 1));
        check($sformatf("inord%0d.tlb", i - 1), new_tlb_entry, i == 2);
      end
      if (i == 2) check("inord.tlbinfo", new_tlb_info, {20'h12345, 20'h00abc});
    end
    tick();
    expect_idle("inord.done");
    // simultaneous fills of ids 4 and 5, with an alloc landing on the commit edge
    alloc(2);
    fill_cache(4'd4, 32'h44, 5'b0);
    fill_mul(4'd5, 32'h55);
    tick();
    expect_idle("sim.wait");
    alloc_valid = 1'b1;
    tick();
    expect_commit("sim4", 4'd4, 32'h44);
    tick();
    expect_commit("sim5", 4'd5, 32'h55);
    tick();
    expect_idle("sim.done");
    alloc(6);
    check("sim.full6", rob_full, 1'b0);
    alloc(1);
    check("sim.full7", rob_full, 1'b1);
    // out-of-order fill
    do_reset();
    alloc(3);
    fill_mul(4'd2, 32'h222);
    tick();
    expect_idle("ooo.m2");
    fill_cache(4'd1, 32'h111, 5'b0);
    tick();
    expect_idle("ooo.c1");
    tick();
    expect_idle("ooo.gap");
    fill_cache(4'd0, 32'h100, 5'b0);
    tick();
    expect_idle("ooo.c0");
    tick();
    expect_commit("ooo0", 4'd0, 32'h100);
    tick();
    expect_commit("ooo1", 4'd1, 32'h111);
    tick();
    expect_commit("ooo2", 4'd2, 32'h222);
    tick();
    expect_idle("ooo.done");
    // exception on id1 with id2 already valid
    do_reset();
    alloc(3);
    fill_mul(4'd2, 32'h2);
    tick();
    fill_cache(4'd0, 32'h10, 5'b0);
    tick();
    req = mk(4'd1, 32'h11, 5'b00001);
    req.xcpt_addr = 32'hDEAD;
    cache_wb_info = req;
    cache_wb_valid = 1'b1;
    tick();
    expect_commit("xc0", 4'd0, 32'h10);
    tick();
    check("xc.xv", xcpt_valid, 1'b1);
    check("xc.flush", flush_pipeline, 1'b1);
    check("xc.wen", rf_wen, 1'b0);
    check("xc.cv", commit_valid, 1'b0);
    check("xc.cause", xcpt_info.cause, XCPT_DTLB_MISS);
    check("xc.pc", xcpt_info.pc, 32'h1004);
    check("xc.addr", xcpt_info.addr, 32'hDEAD);
    alloc_valid = 1'b1;
    fill_cache(4'd2, 32'h99, 5'b0);
    tick();
    expect_idle("xc.flush1");
    check("xc.xv1", xcpt_valid, 1'b0);
    tick();
    expect_idle("xc.id2gone");
    alloc(1);
    fill_cache(4'd2, 32'h22, 5'b0);
    tick();
    expect_idle("xc.refill");
    tick();
    expect_commit("xc.restart", 4'd2, 32'h22);
    alloc(7);
    check("xc.full7", rob_full, 1'b0);
    alloc(1);
    check("xc.full8", rob_full, 1'b1);
    // full and wrap
    do_reset();
    alloc(7);
    check("wrap.full7", rob_full, 1'b0);
    alloc(1);
    check("wrap.full8", rob_full, 1'b1);
    fill_cache(4'd0, 32'h100, 5'b0);
    tick();
    check("wrap.fillfull", rob_full, 1'b1);
    tick();
    expect_commit("wrap0", 4'd0, 32'h100);
    check("wrap.retire", rob_full, 1'b0);
    alloc(1);
    check("wrap.refull", rob_full, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      fill_cache(4'(i), 32'h100 + 32'(i), 5'b0);
      tick();
      if (i > 1) expect_commit($sformatf("wrap%0d", i - 1), 4'(i - 1), 32'h100 + 32'(i - 1));
    end
    tick();
    expect_commit("wrap8", 4'd8, 32'h108);
    check("wrap.empty", rob_full, 1'b0);
    // reset during the flush cycle, fetch outranks alu
    do_reset();
    alloc(2);
    req = mk(4'd0, 32'h0, 5'b10100);
    req.xcpt_addr = 32'h44;
    cache_wb_info = req;
    cache_wb_valid = 1'b1;
    tick();
    tick();
    check("rf.flush", flush_pipeline, 1'b1);
    check("rf.cause", xcpt_info.cause, XCPT_FETCH);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_idle("rf.reset");
    check("rf.xv", xcpt_valid, 1'b0);
    check("rf.xinfo", xcpt_info, '0);
    check("rf.full", rob_full, 1'b0);
    alloc(1);
    fill_cache(4'd0, 32'h77, 5'b0);
    tick();
    tick();
    expect_commit("rf.head0", 4'd0, 32'h77);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
